// File: rtl/swap_checker_pkg.sv
// Shared definitions for the swap_checker slice: FSM state encodings and
// the default data width, so the swap producer and the checker agree.
package swap_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_ACQ   = 2'd2,
        S_LOCK  = 2'd3
    } state_e;

    localparam int DEF_WIDTH = 8;

    // Good-run counter width; LOCK_N is limited to 1..255.
    localparam int RUN_W = 8;

endpackage

// File: rtl/swap_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports: clk, rst (async, active-high), inc, clr, q[W-1:0].
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/swap_checker.sv
// Swap-interface monitor: checks a(t)==b(t-1) and b(t)==a(t-1) every clock,
// and reports lock, an error flag, and good-swap / mismatch counts.
// Ports: clk, rst (async, active-high), en, a_in, b_in -> locked, err,
//        swap_cnt (wrapping), err_cnt (saturating).
// Build option: define SWAP_CHK_STICKY_EN to make err sticky (cleared by
// rst or en low) instead of a one-cycle pulse.
module swap_checker
    import swap_checker_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LOCK_N = 4,
    parameter int CNT_W  = 16,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] swap_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_N - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   prev_a_q;
    logic [WIDTH-1:0]   prev_b_q;
    logic [RUN_W-1:0]   run_q;
    logic               locked_q;
    logic               err_q;
    logic [CNT_W-1:0]   swap_cnt_q;
    logic               good;
    logic               err_inc;

    assign good = (a_in == prev_b_q) && (b_in == prev_a_q);

    // A mismatch is only counted when it knocks us out of lock.
    assign err_inc = en && (state_q == S_LOCK) && !good;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prev_a_q   <= '0;
            prev_b_q   <= '0;
            run_q      <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            swap_cnt_q <= '0;
        end else if (!en) begin
            // Counters hold; prev pair is frozen until re-enabled.
            state_q  <= S_IDLE;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            prev_a_q <= a_in;
            prev_b_q <= b_in;
`ifndef SWAP_CHK_STICKY_EN
            err_q    <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    state_q <= S_PRIME;
                end
                S_PRIME: begin
                    run_q   <= '0;
                    state_q <= S_ACQ;
                end
                S_ACQ: begin
                    if (!good) begin
                        run_q <= '0;
                    end else if (run_q == RUN_LAST) begin
                        run_q    <= '0;
                        locked_q <= 1'b1;
                        state_q  <= S_LOCK;
                    end else begin
                        run_q <= run_q + 8'd1;
                    end
                end
                S_LOCK: begin
                    if (good) begin
                        swap_cnt_q <= swap_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        err_q    <= 1'b1;
                        locked_q <= 1'b0;
                        run_q    <= '0;
                        state_q  <= S_ACQ;
                    end
                end
            endcase
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .clr (1'b0),
        .q   (err_cnt)
    );

    assign locked   = locked_q;
    assign err      = err_q;
    assign swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_swap_checker.sv
// Scoreboard bench for swap_checker: a behavioural model predicts each
// cycle's outputs, a monitor compares them against the DUT.
module tb_swap_checker;

    localparam int LOCK_N  = 4;
    localparam int ERR_W   = 2;
    localparam int ERR_MAX = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       locked;
    logic       err;
    logic [15:0] swap_cnt;
    logic [ERR_W-1:0] err_cnt;

    swap_checker #(
        .WIDTH (8),
        .LOCK_N(LOCK_N),
        .CNT_W (16),
        .ERR_W (ERR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .a_in    (a_in),
        .b_in    (b_in),
        .locked  (locked),
        .err     (err),
        .swap_cnt(swap_cnt),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit locked;
        bit err;
        int swap;
        int errc;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: counts of enabled edges and good streak.
    int en_run, streak, m_swap, m_errcnt;
    bit m_locked, m_err;
    logic [7:0] m_pa, m_pb;

    // Producer generator: last pair driven while enabled.
    logic [7:0] ga = 8'h34;
    logic [7:0] gb = 8'h12;

    task automatic model_reset();
        en_run = 0; streak = 0; m_swap = 0; m_errcnt = 0;
        m_locked = 0; m_err = 0; m_pa = '0; m_pb = '0;
    endtask

    task automatic model(input bit e, input logic [7:0] a,
                         input logic [7:0] b);
        bit g;
        g = (a == m_pb) && (b == m_pa);
        if (!e) begin
            en_run = 0; m_locked = 0; m_err = 0;
        end else begin
`ifndef SWAP_CHK_STICKY_EN
            m_err = 0;
`endif
            en_run++;
            // Edge 1 leaves IDLE, edge 2 primes; checks start at edge 3.
            if (en_run == 2) streak = 0;
            if (en_run >= 3) begin
                if (m_locked) begin
                    if (g) m_swap = (m_swap + 1) % 65536;
                    else begin
                        m_err = 1; m_locked = 0; streak = 0;
                        if (m_errcnt < ERR_MAX) m_errcnt++;
                    end
                end else if (g) begin
                    streak++;
                    if (streak == LOCK_N) begin
                        m_locked = 1; streak = 0;
                    end
                end else streak = 0;
            end
            m_pa = a; m_pb = b;
        end
    endtask

    task automatic step(input bit e, input logic [7:0] a,
                        input logic [7:0] b);
        exp_t x;
        @(negedge clk);
        en = e; a_in = a; b_in = b;
        model(e, a, b);
        x.locked = m_locked; x.err = m_err;
        x.swap = m_swap; x.errc = m_errcnt;
        q.push_back(x);
    endtask

    task automatic drv(input bit e, input bit bad);
        logic [7:0] a, b;
        a = gb; b = ga;
        if (bad) a = ~a;
        step(e, a, b);
        if (e) begin ga = a; gb = b; end
    endtask

    task automatic spot(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic mid_reset();
        exp_t x;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        spot("async_rst_locked", int'(locked), 0);
        spot("async_rst_err", int'(err), 0);
        spot("async_rst_swap", int'(swap_cnt), 0);
        spot("async_rst_errcnt", int'(err_cnt), 0);
        model_reset();
        x.locked = 0; x.err = 0; x.swap = 0; x.errc = 0;
        q.push_back(x);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Monitor: every edge with a pending expectation is compared.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                n_checks++;
                if (locked !== x.locked || err !== x.err ||
                    swap_cnt !== 16'(x.swap) ||
                    err_cnt !== ERR_W'(x.errc)) begin
                    n_fail++;
                    $display("FAIL cycle t=%0t: got l=%0b e=%0b s=%0d c=%0d expected l=%0b e=%0b s=%0d c=%0d",
                             $time, locked, err, swap_cnt, err_cnt,
                             x.locked, x.err, x.swap, x.errc);
                end
            end
        end
    end

    initial begin
        model_reset();
        #1;
        spot("reset_locked", int'(locked), 0);
        spot("reset_err", int'(err), 0);
        spot("reset_swap", int'(swap_cnt), 0);
        spot("reset_errcnt", int'(err_cnt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Lock acquisition on the sixth enabled edge.
        repeat (6) drv(1, 0);
        @(posedge clk);
        #2 spot("lock_6th_edge", int'(locked), 1);

        // Count 10 swaps, then drop enable.
        repeat (10) drv(1, 0);
        repeat (5) drv(0, 0);
        @(posedge clk);
        #2 spot("en_drop_swap_hold", int'(swap_cnt), 10);
        spot("en_drop_unlocked", int'(locked), 0);
        repeat (8) drv(1, 0);

        // Single corruption, relock, then a burst of three.
        drv(1, 1);
        repeat (8) drv(1, 0);
        repeat (3) drv(1, 1);
        repeat (8) drv(1, 0);

        // Constant equal data counts as good.
        repeat (8) step(1, 8'h55, 8'h55);
        ga = 8'h55; gb = 8'h55;

        // Repeated lock/mismatch to saturate err_cnt.
        repeat (5) begin
            repeat (5) drv(1, 0);
            drv(1, 1);
        end
        @(posedge clk);
        #2 spot("errcnt_saturated", int'(err_cnt), ERR_MAX);
        repeat (2) drv(0, 0);
        repeat (8) drv(1, 0);

        mid_reset();

        // Randomized traffic with occasional corruption and en drops.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                step(1, 8'($urandom), 8'($urandom));
                ga = m_pa; gb = m_pb;
            end else begin
                drv($urandom_range(0, 24) != 0,
                    $urandom_range(0, 14) == 0);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0",
                     q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
